histogram_cdf_uretici: RTL and testbench

HISTOGRAM_CDF_URETICI -- requirements
Module: histogram_cdf_uretici

---
 rtl/histogram_cdf_uretici_pkg.sv | 27 ++
 rtl/histogram_cdf_uretici.sv | 192 +++++++++++++++++++
 tb/tb_histogram_cdf_uretici.sv | 315 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/histogram_cdf_uretici_pkg.sv
// Shared constants for the histogram / CDF path of the equalizer.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
//
// Holds the controller state encoding and the bin/count width so that the
// equalization stage decodes durum_o and sizes its CDF inputs identically.
package histogram_cdf_uretici_pkg;

    // Bin, counter and accumulator width: a 17-bit count covers frames of up
    // to 131071 pixels, which bounds every partial sum of the CDF as well.
    localparam int BIN_W      = 17;
    localparam int GRI_W      = 8;
    localparam int BIN_SAYISI = 1 << GRI_W;

    typedef logic [BIN_W-1:0] bin_t;
    typedef logic [GRI_W-1:0] gri_t;

    // TEMIZLE: clear bins, TOPLA: count pixels, BIRIKTIR: prefix-sum bins,
    // SUN: serve CDF lookups.
    typedef enum logic [1:0] {
        TEMIZLE  = 2'd0,
        TOPLA    = 2'd1,
        BIRIKTIR = 2'd2,
        SUN      = 2'd3
    } durum_t;

endpackage

// File: rtl/histogram_cdf_uretici.sv
// Builds a per-frame grey-level histogram, turns it in place into a CDF and serves CDF lookups.
// Latency: pixel counted in its accept cycle; lookup answered 1 cycle after acceptance.
// Backpressure: pixels accepted only while hazir_o=1; stal_i freezes the answer registers and query counter.
//
// Ports:
//   clk_i, rst_i                      clock, asynchronous active-high reset
//   piksel_gecerli_i, piksel_i        pixel stream (counted only in TOPLA)
//   sorgu_gecerli_i, sorgu_piksel_i   CDF lookup requests (served only in SUN)
//   stal_i                            downstream stall, holds the serve pipeline
//   etkin_o, cdf_o, cdf_min_o         lookup answer and frame minimum non-zero CDF
//   hazir_o                           ready for pixels (TOPLA)
//   durum_o                           current controller state
//
// Frame flow: TEMIZLE (256 cycles, one bin cleared per cycle) -> TOPLA (M*N
// pixels) -> BIRIKTIR (256 cycles, bins replaced by running sums) -> SUN (M*N
// answered lookups plus one cycle to present the last answer) -> TEMIZLE.
// The bins have a single write port and are read combinationally, so the array
// maps either onto flops or onto a RAM with one write and two read accesses.
module histogram_cdf_uretici
    import histogram_cdf_uretici_pkg::*;
#(
    parameter int M = 320,
    parameter int N = 240
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             piksel_gecerli_i,
    input  logic [GRI_W-1:0] piksel_i,
    input  logic             sorgu_gecerli_i,
    input  logic [GRI_W-1:0] sorgu_piksel_i,
    input  logic             stal_i,
    output logic             etkin_o,
    output logic [BIN_W-1:0] cdf_o,
    output logic [BIN_W-1:0] cdf_min_o,
    output logic             hazir_o,
    output logic [1:0]       durum_o
);

    // Pixels per frame, also the number of lookups served per frame.
    localparam bin_t PIKSEL_SAYISI = bin_t'(M * N);
    localparam bin_t BIR           = bin_t'(1);
    localparam gri_t SON_INDEKS    = gri_t'(BIN_SAYISI - 1);

    // Controller and datapath registers.
    durum_t durum_q, durum_d;
    gri_t   indeks_q, indeks_d;
    bin_t   sayac_q, sayac_d;
    bin_t   acc_q, acc_d;
    bin_t   cdf_min_q, cdf_min_d;

    // Registered lookup answer.
    logic   etkin_q, etkin_d;
    bin_t   cdf_q, cdf_d;
    bin_t   cdf_min_cikis_q, cdf_min_cikis_d;

    // Histogram / CDF storage; cleared by the TEMIZLE pass, not by reset.
    bin_t   bin_q [BIN_SAYISI];

    // Single bin write port, driven by whichever phase owns the array.
    logic   bin_yaz_en;
    gri_t   bin_yaz_adr;
    bin_t   bin_yaz_dat;

    // Running sum for the current BIRIKTIR index.
    bin_t   toplam;
    logic   indeks_son;

    always_comb begin
        durum_d         = durum_q;
        indeks_d        = indeks_q;
        sayac_d         = sayac_q;
        acc_d           = acc_q;
        cdf_min_d       = cdf_min_q;
        etkin_d         = 1'b0;
        cdf_d           = cdf_q;
        cdf_min_cikis_d = cdf_min_cikis_q;
        bin_yaz_en      = 1'b0;
        bin_yaz_adr     = indeks_q;
        bin_yaz_dat     = '0;
        toplam          = acc_q + bin_q[indeks_q];
        indeks_son      = (indeks_q == SON_INDEKS);

        unique case (durum_q)
            TEMIZLE: begin
                // Counter, accumulator and minimum stay cleared for the whole
                // pass, so they start from zero however the pass was entered.
                bin_yaz_en  = 1'b1;
                bin_yaz_dat = '0;
                indeks_d    = indeks_q + 8'd1;
                sayac_d     = '0;
                acc_d       = '0;
                cdf_min_d   = '0;
                if (indeks_son) begin
                    durum_d = TOPLA;
                end
            end

            TOPLA: begin
                if (piksel_gecerli_i) begin
                    // Read and write the same bin in one cycle: consecutive
                    // equal pixels each see the previous increment.
                    bin_yaz_en  = 1'b1;
                    bin_yaz_adr = piksel_i;
                    bin_yaz_dat = bin_q[piksel_i] + BIR;
                    sayac_d     = sayac_q + BIR;
                    if (sayac_q == PIKSEL_SAYISI - BIR) begin
                        durum_d = BIRIKTIR;
                        sayac_d = '0;
                    end
                end
            end

            BIRIKTIR: begin
                bin_yaz_en  = 1'b1;
                bin_yaz_dat = toplam;
                acc_d       = toplam;
                // The running sum never decreases, so the first non-zero sum
                // is the smallest non-zero CDF value of the frame.
                if ((cdf_min_q == '0) && (toplam != '0)) begin
                    cdf_min_d = toplam;
                end
                indeks_d = indeks_q + 8'd1;
                if (indeks_son) begin
                    durum_d = SUN;
                    sayac_d = '0;
                end
            end

            SUN: begin
                if (stal_i) begin
                    // Answer, counter and state all hold; a query presented
                    // now is dropped and must be re-issued by the source.
                    etkin_d = etkin_q;
                end else if (sayac_q == PIKSEL_SAYISI) begin
                    // The last answer is on the outputs this cycle; leave
                    // only after it has been taken (no stall).
                    durum_d   = TEMIZLE;
                    sayac_d   = '0;
                    acc_d     = '0;
                    cdf_min_d = '0;
                end else begin
                    etkin_d = sorgu_gecerli_i;
                    if (sorgu_gecerli_i) begin
                        cdf_d           = bin_q[sorgu_piksel_i];
                        cdf_min_cikis_d = cdf_min_q;
                        sayac_d         = sayac_q + BIR;
                    end
                end
            end

            default: begin
                durum_d = TEMIZLE;
            end
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            durum_q         <= TEMIZLE;
            indeks_q        <= '0;
            sayac_q         <= '0;
            acc_q           <= '0;
            cdf_min_q       <= '0;
            etkin_q         <= 1'b0;
            cdf_q           <= '0;
            cdf_min_cikis_q <= '0;
        end else begin
            durum_q         <= durum_d;
            indeks_q        <= indeks_d;
            sayac_q         <= sayac_d;
            acc_q           <= acc_d;
            cdf_min_q       <= cdf_min_d;
            etkin_q         <= etkin_d;
            cdf_q           <= cdf_d;
            cdf_min_cikis_q <= cdf_min_cikis_d;
        end
    end

    // Bin array: no reset, so it can be implemented as a RAM.
    always_ff @(posedge clk_i) begin
        if (bin_yaz_en) begin
            bin_q[bin_yaz_adr] <= bin_yaz_dat;
        end
    end

    assign etkin_o   = etkin_q;
    assign cdf_o     = cdf_q;
    assign cdf_min_o = cdf_min_cikis_q;
    assign hazir_o   = (durum_q == TOPLA);
    assign durum_o   = durum_q;

endmodule

// File: tb/tb_histogram_cdf_uretici.sv
// Self-checking bench for histogram_cdf_uretici with a 4x4 frame.
// Latency: n/a.
// Backpressure: exercises stal_i during the lookup stream.
module tb_histogram_cdf_uretici;

    localparam int M  = 4;
    localparam int N  = 4;
    localparam int NP = M * N;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic        piksel_gecerli_i;
    logic [7:0]  piksel_i;
    logic        sorgu_gecerli_i;
    logic [7:0]  sorgu_piksel_i;
    logic        stal_i;
    logic        etkin_o;
    logic [16:0] cdf_o;
    logic [16:0] cdf_min_o;
    logic        hazir_o;
    logic [1:0]  durum_o;

    histogram_cdf_uretici #(.M(M), .N(N)) dut (
        .clk_i            (clk_i),
        .rst_i            (rst_i),
        .piksel_gecerli_i (piksel_gecerli_i),
        .piksel_i         (piksel_i),
        .sorgu_gecerli_i  (sorgu_gecerli_i),
        .sorgu_piksel_i   (sorgu_piksel_i),
        .stal_i           (stal_i),
        .etkin_o          (etkin_o),
        .cdf_o            (cdf_o),
        .cdf_min_o        (cdf_min_o),
        .hazir_o          (hazir_o),
        .durum_o          (durum_o)
    );

    always #5 clk_i = ~clk_i;

    int n_karsilastirma = 0;
    int n_uyumsuz       = 0;

    // Reference model: pixel counts per grey level, derived CDF and minimum.
    int hist [256];
    int cdf_m [256];
    int cmin_m;

    int piksel_kuyruk [$];
    int sorgu_kuyruk [$];

    task automatic kontrol(input string etiket, input logic [31:0] gozlenen,
                           input logic [31:0] beklenen);
        n_karsilastirma++;
        if (gozlenen !== beklenen) begin
            n_uyumsuz++;
            $display("FAIL %s: observed %0d expected %0d (t=%0t)", etiket, gozlenen, beklenen, $time);
        end
    endtask

    task automatic model_temizle();
        for (int i = 0; i < 256; i++) hist[i] = 0;
    endtask

    // CDF(v) = number of frame pixels with grey value <= v;
    // cdf_min = smallest non-zero value among those.
    task automatic model_hesapla();
        cmin_m = 0;
        for (int v = 0; v < 256; v++) begin
            cdf_m[v] = 0;
            for (int g = 0; g <= v; g++) cdf_m[v] += hist[g];
            if (cdf_m[v] != 0 && (cmin_m == 0 || cdf_m[v] < cmin_m)) cmin_m = cdf_m[v];
        end
    endtask

    task automatic girisleri_bosalt();
        piksel_gecerli_i = 1'b0;
        piksel_i         = 8'd0;
        sorgu_gecerli_i  = 1'b0;
        sorgu_piksel_i   = 8'd0;
        stal_i           = 1'b0;
    endtask

    task automatic sifir_kontrol(input string e);
        kontrol({e, "_durum"},   32'(durum_o),   0);
        kontrol({e, "_etkin"},   32'(etkin_o),   0);
        kontrol({e, "_cdf"},     32'(cdf_o),     0);
        kontrol({e, "_cdf_min"}, 32'(cdf_min_o), 0);
        kontrol({e, "_hazir"},   32'(hazir_o),   0);
    endtask

    // Reset, then check the 256-cycle clear pass before pixels are accepted.
    task automatic reset_ve_temizle(input string e);
        int dusuk;
        girisleri_bosalt();
        rst_i = 1'b1;
        repeat (2) @(negedge clk_i);
        sifir_kontrol(e);
        rst_i = 1'b0;
        dusuk = 0;
        for (int i = 0; i < 256; i++) begin
            if (!hazir_o) dusuk++;
            @(negedge clk_i);
        end
        kontrol({e, "_temizle_sure"}, dusuk, 256);
        kontrol({e, "_temizle_sonu_hazir"}, 32'(hazir_o), 1);
        model_temizle();
    endtask

    task automatic topla_bekle();
        int g = 0;
        while (!hazir_o && g < 400) begin
            @(negedge clk_i);
            g++;
        end
        kontrol("topla_bekle", 32'(hazir_o), 1);
    endtask

    // Feed the pixel queue; optional idle gaps carry stray queries.
    task automatic besle(input bit bosluklu);
        int i = 0;
        bit etkin_goruldu = 1'b0;
        while (i < piksel_kuyruk.size()) begin
            if (etkin_o) etkin_goruldu = 1'b1;
            if (bosluklu && $urandom_range(0, 3) == 0) begin
                piksel_gecerli_i = 1'b0;
                piksel_i         = 8'($urandom);
            end else begin
                piksel_gecerli_i = 1'b1;
                piksel_i         = 8'(piksel_kuyruk[i]);
                hist[piksel_kuyruk[i]]++;
                i++;
            end
            sorgu_gecerli_i = 1'($urandom_range(0, 1));
            sorgu_piksel_i  = 8'($urandom);
            @(negedge clk_i);
        end
        piksel_gecerli_i = 1'b0;
        sorgu_gecerli_i  = 1'b0;
        kontrol("topla_etkin", 32'(etkin_goruldu), 0);
        kontrol("biriktir_gecis", 32'(durum_o), 2);
    endtask

    // Accumulate phase with stray pixels and queries on every cycle.
    task automatic sun_bekle();
        int g = 0;
        bit e = 1'b0;
        while (durum_o != 2'd3 && g < 600) begin
            if (etkin_o) e = 1'b1;
            piksel_gecerli_i = 1'b1;
            piksel_i         = 8'($urandom);
            sorgu_gecerli_i  = 1'b1;
            sorgu_piksel_i   = 8'($urandom);
            @(negedge clk_i);
            g++;
        end
        girisleri_bosalt();
        kontrol("biriktir_sure", g, 256);
        kontrol("biriktir_etkin", 32'(e), 0);
        model_hesapla();
    endtask

    // Lookup phase: directed queries first, then random ones.
    task automatic sun_fazi(input bit stal_modu, input bit rastgele_stal);
        int   kabul = 0;
        int   g = 0;
        int   stal_kalan = 0;
        bit   stal_yapildi = 1'b0;
        bit   st;
        bit   gec;
        int   q;
        logic b_etkin = 1'b0;
        int   b_cdf = 0;
        int   b_min = 0;
        while (kabul < NP && g < 500) begin
            kontrol("sun_durum", 32'(durum_o), 3);
            kontrol("etkin", 32'(etkin_o), 32'(b_etkin));
            if (b_etkin) begin
                kontrol("cdf", 32'(cdf_o), b_cdf);
                kontrol("cdf_min", 32'(cdf_min_o), b_min);
            end
            if (stal_modu && kabul == 5 && !stal_yapildi) begin
                stal_kalan   = 3;
                stal_yapildi = 1'b1;
            end
            if (stal_kalan > 0) begin
                st = 1'b1;
                stal_kalan--;
            end else begin
                st = rastgele_stal && ($urandom_range(0, 7) == 0);
            end
            gec = st ? 1'b1 : ($urandom_range(0, 3) != 0);
            q   = (kabul < sorgu_kuyruk.size()) ? sorgu_kuyruk[kabul] : int'($urandom_range(0, 255));
            stal_i           = st;
            sorgu_gecerli_i  = gec;
            sorgu_piksel_i   = 8'(q);
            piksel_gecerli_i = 1'($urandom_range(0, 1));
            piksel_i         = 8'($urandom);
            if (!st) begin
                b_etkin = gec;
                if (gec) begin
                    b_cdf = cdf_m[q];
                    b_min = cmin_m;
                    kabul++;
                end
            end
            @(negedge clk_i);
            g++;
        end
        kontrol("sun_kabul", kabul, NP);
        // Last answer is presented while still in SUN; a further query is ignored.
        kontrol("son_cevap_etkin", 32'(etkin_o), 32'(b_etkin));
        kontrol("son_cevap_cdf", 32'(cdf_o), b_cdf);
        kontrol("son_cevap_durum", 32'(durum_o), 3);
        stal_i          = 1'b0;
        sorgu_gecerli_i = 1'b1;
        sorgu_piksel_i  = 8'($urandom);
        @(negedge clk_i);
        kontrol("bitis_etkin", 32'(etkin_o), 0);
        kontrol("bitis_durum", 32'(durum_o), 0);
        girisleri_bosalt();
    endtask

    task automatic cerceve(input bit bosluklu, input bit stal_modu, input bit rastgele_stal);
        topla_bekle();
        besle(bosluklu);
        sun_bekle();
        sun_fazi(stal_modu, rastgele_stal);
    endtask

    task automatic rastgele_pikseller();
        int mod;
        piksel_kuyruk = {};
        mod = int'($urandom_range(0, 2));
        for (int i = 0; i < NP; i++) begin
            if (mod == 0)      piksel_kuyruk.push_back(int'($urandom_range(0, 255)));
            else if (mod == 1) piksel_kuyruk.push_back(int'($urandom_range(0, 3)));
            else               piksel_kuyruk.push_back(int'($urandom_range(250, 255)));
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        girisleri_bosalt();
        rst_i = 1'b1;
        model_temizle();
        @(negedge clk_i);
        reset_ve_temizle("reset");

        // Single grey level.
        piksel_kuyruk = {};
        repeat (NP) piksel_kuyruk.push_back(5);
        sorgu_kuyruk = {5, 0, 255};
        cerceve(1'b0, 1'b0, 1'b0);

        // One pixel of each value 0..15.
        model_temizle();
        piksel_kuyruk = {};
        for (int i = 0; i < NP; i++) piksel_kuyruk.push_back(i);
        sorgu_kuyruk = {7, 255};
        cerceve(1'b1, 1'b0, 1'b0);

        // Back-to-back equal values.
        model_temizle();
        piksel_kuyruk = {};
        repeat (8) piksel_kuyruk.push_back(3);
        repeat (8) piksel_kuyruk.push_back(200);
        sorgu_kuyruk = {3, 199, 200};
        cerceve(1'b0, 1'b0, 1'b0);

        // Three-cycle stall in the middle of the lookup stream.
        model_temizle();
        rastgele_pikseller();
        sorgu_kuyruk = {};
        cerceve(1'b1, 1'b1, 1'b0);

        // Reset after 7 pixels: the partial counts must vanish.
        model_temizle();
        topla_bekle();
        for (int i = 0; i < 7; i++) begin
            piksel_gecerli_i = 1'b1;
            piksel_i         = 8'(9 - (i % 2));
            @(negedge clk_i);
        end
        reset_ve_temizle("orta_reset");
        piksel_kuyruk = {};
        repeat (NP) piksel_kuyruk.push_back(9);
        sorgu_kuyruk = {9, 8};
        cerceve(1'b0, 1'b0, 1'b0);

        // Reset during accumulation, then a fresh random frame.
        model_temizle();
        rastgele_pikseller();
        topla_bekle();
        besle(1'b1);
        repeat (50) @(negedge clk_i);
        reset_ve_temizle("biriktir_reset");

        // Random frames with random stalls.
        for (int f = 0; f < 4; f++) begin
            model_temizle();
            rastgele_pikseller();
            sorgu_kuyruk = {};
            cerceve(1'b1, 1'b0, 1'b1);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_karsilastirma, n_uyumsuz);
        $finish;
    end

endmodule
